lfsr_checker: RTL and testbench

// - Receive-side counterpart of the DAC MLS generator: checks the hard-sliced ADC bit stream against the same LFSR polynomial.
// - Self-synchronises its predictor from received bits, declares lock, counts bit errors and marks sequence periods.
// - Sits after the ADC sign-slicer in the ADC-side AXIS path; drives status registers for excitation quality and alignment.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_checker_if.sv | 22 ++
 rtl/clk_div_stb.sv | 22 ++
 rtl/lfsr_checker.sv | 159 +++++++++++++++
 tb/tb_lfsr_checker.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types, constants and XNOR next-bit helper (generator and checker)
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CHECK,
        ST_LOCKED
    } lfsr_state_e;

    localparam logic [31:0] LFSR_CLEAR = 32'd1;

    // Zero-extended bits do not disturb the parity, so one width serves any LFSR length.
    function automatic logic lfsr_next_bit(input logic [31:0] r, input logic [31:0] mask);
        return ~^(r & mask);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// rtl/lfsr_checker_if.sv - control/status bundle between the ADC slicer path and the checker
interface lfsr_checker_if;
    logic        en;
    logic [7:0]  sel_div_i;
    logic        sig_i;
    logic        clr_i;
    logic        lock_o;
    logic        err_o;
    logic        period_o;
    logic [15:0] err_cnt_o;
    logic [31:0] bit_cnt_o;

    modport master (
        output en, sel_div_i, sig_i, clr_i,
        input  lock_o, err_o, period_o, err_cnt_o, bit_cnt_o
    );

    modport slave (
        input  en, sel_div_i, sig_i, clr_i,
        output lock_o, err_o, period_o, err_cnt_o, bit_cnt_o
    );
endinterface

// File: rtl/clk_div_stb.sv
// rtl/clk_div_stb.sv - 8-bit bit-period prescaler with restart; sel 0 gives a 256-clock period
module clk_div_stb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_restart,
    input  logic [7:0] i_sel_div,
    output logic       o_stb
);
    logic [7:0] r_cnt;

    assign o_stb = (r_cnt == i_sel_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd1;
        end else if (i_restart || o_stb) begin
            r_cnt <= 8'd1;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising MLS checker; LFSR_CHECKER_BER_EN adds error/bit counters
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned        width_p    = 3,
    parameter logic [width_p-1:0] mask_p     = 3'b110,
    parameter int unsigned        lock_cnt_p = 8,
    parameter int unsigned        err_thr_p  = 4
) (
    input logic          clk,
    input logic          arst_n,
    lfsr_checker_if.slave bus
);
    localparam logic [width_p-1:0] R_INIT    = width_p'(LFSR_CLEAR);
    localparam logic [width_p-1:0] R_ONES    = '1;
    localparam logic [7:0]         FILL_LAST = 8'(width_p - 1);
    localparam logic [7:0]         LOCK_LAST = 8'(lock_cnt_p - 1);
    localparam logic [7:0]         ERR_THR   = 8'(err_thr_p);

    lfsr_state_e        r_state;
    logic [width_p-1:0] r_shift;
    logic [7:0]         r_fill;
    logic [7:0]         r_match;
    logic [7:0]         r_errwin;
    logic               r_en_last;
    logic               r_lock;
    logic               r_err;
    logic               r_period;

    logic               w_stb;
    logic               w_en_rise;
    logic               w_act;
    logic               w_pred;
    logic               w_mis;
    logic               w_r_ones;
    logic               w_lck;
    logic               w_err_now;
    logic [width_p-1:0] w_r_rx;
    logic [width_p-1:0] w_r_fly;
    logic [7:0]         w_errwin_inc;

    assign w_en_rise = bus.en & ~r_en_last;

    clk_div_stb u_div (
        .i_clk     (clk),
        .i_rst_n   (arst_n),
        .i_restart (w_en_rise),
        .i_sel_div (bus.sel_div_i),
        .o_stb     (w_stb)
    );

    // A restart edge owns its clock; the strobe of that same cycle is ignored.
    assign w_act        = bus.en & ~w_en_rise & w_stb;
    assign w_pred       = lfsr_next_bit(32'(r_shift), 32'(mask_p));
    assign w_mis        = bus.sig_i ^ w_pred;
    assign w_r_ones     = &r_shift;
    assign w_lck        = w_act & (r_state == ST_LOCKED);
    assign w_err_now    = w_mis & ((w_act & (r_state == ST_CHECK) & ~w_r_ones) | w_lck);
    assign w_r_rx       = {r_shift[width_p-2:0], bus.sig_i};
    assign w_r_fly      = {r_shift[width_p-2:0], w_pred};
    assign w_errwin_inc = r_errwin + {7'd0, w_mis};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= R_INIT;
            r_fill    <= 8'd0;
            r_match   <= 8'd0;
            r_errwin  <= 8'd0;
            r_en_last <= 1'b0;
            r_lock    <= 1'b0;
            r_err     <= 1'b0;
            r_period  <= 1'b0;
        end else begin
            r_en_last <= bus.en;
            r_err     <= w_err_now;
            r_period  <= 1'b0;
            if (!bus.en) begin
                r_state <= ST_IDLE;
                r_lock  <= 1'b0;
            end else if (w_en_rise) begin
                r_state <= ST_FILL;
                r_fill  <= 8'd0;
                r_lock  <= 1'b0;
            end else if (w_stb) begin
                case (r_state)
                    ST_FILL: begin
                        r_shift <= w_r_rx;
                        if (r_fill == FILL_LAST) begin
                            r_state <= ST_CHECK;
                            r_match <= 8'd0;
                        end else begin
                            r_fill <= r_fill + 8'd1;
                        end
                    end
                    ST_CHECK: begin
                        r_shift <= w_r_rx;
                        // All-ones is the XNOR lockup window: no verdict until a 0 arrives.
                        if (w_r_ones || w_mis) begin
                            r_match <= 8'd0;
                        end else if (r_match == LOCK_LAST) begin
                            r_state  <= ST_LOCKED;
                            r_lock   <= 1'b1;
                            r_errwin <= 8'd0;
                        end else begin
                            r_match <= r_match + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        r_shift  <= w_r_fly;
                        r_period <= (w_r_fly == R_INIT);
                        r_errwin <= (w_r_fly == R_INIT) ? 8'd0 : w_errwin_inc;
                        if ((r_shift == R_ONES) || (w_errwin_inc == ERR_THR)) begin
                            r_state  <= ST_FILL;
                            r_fill   <= 8'd0;
                            r_lock   <= 1'b0;
                            r_errwin <= 8'd0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.lock_o   = r_lock;
    assign bus.err_o    = r_err;
    assign bus.period_o = r_period;

`ifdef LFSR_CHECKER_BER_EN
    logic [15:0] r_err_cnt;
    logic [31:0] r_bit_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_err_cnt <= 16'd0;
            r_bit_cnt <= 32'd0;
        end else if (bus.clr_i) begin
            r_err_cnt <= 16'd0;
            r_bit_cnt <= 32'd0;
        end else begin
            if (w_err_now && (r_err_cnt != 16'hffff)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_lck && (r_bit_cnt != 32'hffff_ffff)) begin
                r_bit_cnt <= r_bit_cnt + 32'd1;
            end
        end
    end

    assign bus.err_cnt_o = r_err_cnt;
    assign bus.bit_cnt_o = r_bit_cnt;
`else
    assign bus.err_cnt_o = 16'd0;
    assign bus.bit_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized loopback/noise bench for lfsr_checker against a bit-level reference
module tb_lfsr_checker;
    localparam int W    = 3;
    localparam int MASK = 6;
    localparam int LOCK = 8;
    localparam int THR  = 4;
    localparam int ALL  = (1 << W) - 1;
`ifdef LFSR_CHECKER_BER_EN
    localparam bit BER = 1'b1;
`else
    localparam bit BER = 1'b0;
`endif

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    lfsr_checker_if bus ();

    lfsr_checker #(
        .width_p    (3),
        .mask_p     (3'b110),
        .lock_cnt_p (8),
        .err_thr_p  (4)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference: mode 0 off, 1 filling, 2 hunting, 3 locked
    int     m_mode, m_win, m_fill, m_run, m_ewin;
    longint m_errs, m_bits;
    int     gen;
    int     per_clk;
    bit     last_lock, last_per, last_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int xnor_par(input int v);
        return 1 - ($countones(v & MASK) % 2);
    endfunction

    function automatic bit gen_next();
        int b;
        b   = xnor_par(gen);
        gen = ((gen << 1) | b) & ALL;
        return bit'(b);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_win = 1; m_fill = 0; m_run = 0; m_ewin = 0;
        m_errs = 0; m_bits = 0;
    endfunction

    function automatic void model_bit(input bit b, input bit clr, output bit e_err, output bit e_per);
        int p;
        bit mis, stuck;
        p     = xnor_par(m_win);
        mis   = (int'(b) != p);
        e_err = 1'b0;
        e_per = 1'b0;
        if (m_mode == 1) begin
            m_win = ((m_win << 1) | int'(b)) & ALL;
            m_fill++;
            if (m_fill == W) begin m_mode = 2; m_run = 0; end
        end else if (m_mode == 2) begin
            if (m_win == ALL) m_run = 0;
            else if (mis) begin e_err = 1'b1; m_run = 0; end
            else begin
                m_run++;
                if (m_run == LOCK) begin m_mode = 3; m_ewin = 0; end
            end
            m_win = ((m_win << 1) | int'(b)) & ALL;
        end else if (m_mode == 3) begin
            stuck = (m_win == ALL);
            m_bits++;
            if (mis) begin e_err = 1'b1; m_ewin++; end
            m_win = ((m_win << 1) | p) & ALL;
            e_per = (m_win == 1);
            if (stuck || m_ewin >= THR) begin m_mode = 1; m_fill = 0; m_ewin = 0; end
            else if (e_per) m_ewin = 0;
        end
        if (e_err && m_errs < 65535) m_errs++;
        if (m_bits > 64'hffff_ffff) m_bits = 64'hffff_ffff;
        if (clr) begin m_errs = 0; m_bits = 0; end
    endfunction

    task automatic check_outs(input string tag, input bit e_err, input bit e_per);
        chk({tag, "_lock"},    32'(bus.lock_o),    32'(m_mode == 3));
        chk({tag, "_err"},     32'(bus.err_o),     32'(e_err));
        chk({tag, "_period"},  32'(bus.period_o),  32'(e_per));
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt_o), BER ? 32'(m_errs) : 32'd0);
        chk({tag, "_bit_cnt"}, bus.bit_cnt_o,      BER ? 32'(m_bits) : 32'd0);
    endtask

    // Entered and left on a falling edge; the bit is held for one full bit period.
    task automatic step_bit(input bit b, input bit clr);
        bit e_err, e_per;
        bus.sig_i = b;
        bus.clr_i = clr;
        repeat (per_clk) @(posedge clk);
        @(negedge clk);
        bus.clr_i = 1'b0;
        model_bit(b, clr, e_err, e_per);
        check_outs("bit", e_err, e_per);
        last_lock = bus.lock_o;
        last_per  = bus.period_o;
        last_err  = bus.err_o;
    endtask

    task automatic en_rise();
        bus.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_mode = 1;
        m_fill = 0;
        chk("en_rise_lock", 32'(bus.lock_o), 32'd0);
    endtask

    task automatic en_fall();
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_mode = 0;
        check_outs("en_fall", 1'b0, 1'b0);
    endtask

    task automatic set_div(input logic [7:0] sel);
        bus.sel_div_i = sel;
        per_clk = (sel == 8'd0) ? 256 : int'(sel);
    endtask

    initial begin
        int  lock_at;
        bit  seen_lock, seen_err;
        bus.en    = 1'b0;
        bus.sig_i = 1'b0;
        bus.clr_i = 1'b0;
        set_div(8'd4);
        model_reset();
        repeat (3) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0);
        arst_n = 1'b1;
        @(negedge clk);

        // clean loopback: lock after fill plus lock count
        gen = int'($urandom_range(0, 6));
        en_rise();
        lock_at = -1;
        for (int i = 0; i < 40; i++) begin
            step_bit(gen_next(), 1'b0);
            if (lock_at < 0 && last_lock) lock_at = i + 1;
        end
        chk("lock_latency", 32'(lock_at), 32'(W + LOCK));

        // single flipped bit while locked
        step_bit(~gen_next(), 1'b0);
        chk("single_flip_err", 32'(last_err), 32'd1);
        chk("single_flip_lock", 32'(last_lock), 32'd1);
        for (int i = 0; i < 14; i++) step_bit(gen_next(), 1'b0);

        // four flips right after a period boundary
        for (int i = 0; i < 8 && !last_per; i++) step_bit(gen_next(), 1'b0);
        chk("burst_aligned", 32'(last_per), 32'd1);
        for (int i = 0; i < THR; i++) step_bit(~gen_next(), 1'b0);
        chk("burst_unlock", 32'(last_lock), 32'd0);
        lock_at = -1;
        for (int i = 0; i < 14; i++) begin
            step_bit(gen_next(), 1'b0);
            if (lock_at < 0 && last_lock) lock_at = i + 1;
        end
        chk("burst_relock", 32'(lock_at), 32'(W + LOCK));

        // clear coinciding with an error increment
        step_bit(~gen_next(), 1'b1);
        chk("clr_with_err", 32'(last_err), 32'd1);
        chk("clr_with_err_cnt", 32'(bus.err_cnt_o), 32'd0);

        // random noise with occasional clears
        for (int i = 0; i < 150; i++) begin
            bit b;
            b = gen_next();
            if ($urandom_range(0, 11) == 0) b = ~b;
            step_bit(b, $urandom_range(0, 31) == 0);
        end

        // enable drop while locked
        for (int i = 0; i < 20; i++) step_bit(gen_next(), 1'b0);
        en_fall();
        repeat (5) @(negedge clk);
        check_outs("en_low_hold", 1'b0, 1'b0);

        // stuck-high input: lockup window, never locks, no errors
        en_rise();
        seen_lock = 1'b0;
        seen_err  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_bit(1'b1, 1'b0);
            seen_lock |= last_lock;
            seen_err  |= last_err;
        end
        chk("stuck_no_lock", 32'(seen_lock), 32'd0);
        chk("stuck_no_err", 32'(seen_err), 32'd0);
        for (int i = 0; i < 7 && (gen & 3) != 3; i++) void'(gen_next());
        lock_at = -1;
        for (int i = 0; i < 14; i++) begin
            step_bit(gen_next(), 1'b0);
            if (lock_at < 0 && last_lock) lock_at = i + 1;
        end
        chk("stuck_release_lock", 32'(lock_at > 0 && lock_at <= W + LOCK), 32'd1);

        // slowest and fastest bit periods
        en_fall();
        set_div(8'd0);
        en_rise();
        for (int i = 0; i < 13; i++) step_bit(gen_next(), 1'b0);
        chk("div256_lock", 32'(last_lock), 32'd1);
        en_fall();
        set_div(8'd1);
        en_rise();
        for (int i = 0; i < 30; i++) step_bit(gen_next(), 1'b0);
        chk("div1_lock", 32'(last_lock), 32'd1);

        // asynchronous reset while locked
        arst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_reset", 1'b0, 1'b0);
        bus.en = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        set_div(8'd4);
        en_rise();
        for (int i = 0; i < 20; i++) step_bit(gen_next(), 1'b0);
        chk("post_reset_lock", 32'(last_lock), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
